spi_slave_burst: RTL



---
 rtl/spi_slave_burst_pkg.sv | 17 +
 rtl/spi_slave_burst_sync_edge.sv | 57 +++++
 rtl/spi_slave_burst.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_burst_pkg.sv
// Shared types and constants for the burst-capable SPI target.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_CMD      = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_SHIFT = 3'd4,
    ST_WR_SHIFT = 3'd5,
    ST_DRAIN    = 3'd6
  } state_t;

  localparam logic RW_READ       = 1'b1;
  localparam int   CLK_RATIO_MIN = 16;

endpackage

// File: rtl/spi_slave_burst_sync_edge.sv
// Brings sclk/csz/sdi into the clk domain and turns sclk/csz transitions into
// single-cycle pulses, with sample/shift edges chosen by CPOL/CPHA.
module spi_sync_edge #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic csz,
  input  logic sdi,
  output logic sample_edge,
  output logic shift_edge,
  output logic csz_fall,
  output logic csz_rise,
  output logic sdi_s
);

  logic [1:0] sclk_sync_r;
  logic [1:0] csz_sync_r;
  logic [1:0] sdi_sync_r;
  logic       sclk_prev_r;
  logic       csz_prev_r;
  logic       rise_s;
  logic       fall_s;
  logic       lead_s;
  logic       trail_s;

  // Synchroniser chains plus one history flop per edge-detected input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_r <= {2{CPOL}};
      sclk_prev_r <= CPOL;
      // csz history resets low so a select already held low is not seen as a fall
      csz_sync_r  <= 2'b00;
      csz_prev_r  <= 1'b0;
      sdi_sync_r  <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sclk};
      sclk_prev_r <= sclk_sync_r[1];
      csz_sync_r  <= {csz_sync_r[0], csz};
      csz_prev_r  <= csz_sync_r[1];
      sdi_sync_r  <= {sdi_sync_r[0], sdi};
    end
  end

  assign rise_s      = sclk_sync_r[1] & ~sclk_prev_r;
  assign fall_s      = ~sclk_sync_r[1] & sclk_prev_r;
  assign lead_s      = CPOL ? fall_s : rise_s;
  assign trail_s     = CPOL ? rise_s : fall_s;
  assign sample_edge = CPHA ? trail_s : lead_s;
  assign shift_edge  = CPHA ? lead_s : trail_s;
  assign csz_fall    = csz_prev_r & ~csz_sync_r[1];
  assign csz_rise    = ~csz_prev_r & csz_sync_r[1];
  assign sdi_s       = sdi_sync_r[1];

endmodule

// File: rtl/spi_slave_burst.sv
// SPI target with auto-increment bursts and abort detection, oversampled in the
// clk domain; each completed word becomes a one-cycle mem_req strobe.
module spi_slave_burst
  import spi_slave_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter bit BURST_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              csz,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W);

  logic sample_edge_s, shift_edge_s, csz_fall_s, csz_rise_s, sdi_s;

  spi_sync_edge #(.CPOL(CPOL), .CPHA(CPHA)) u_sync_edge (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .csz         (csz),
    .sdi         (sdi),
    .sample_edge (sample_edge_s),
    .shift_edge  (shift_edge_s),
    .csz_fall    (csz_fall_s),
    .csz_rise    (csz_rise_s),
    .sdi_s       (sdi_s)
  );

  state_t              state_r, state_nxt;
  logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_nxt;
  logic [ADDR_W-1:0]   cur_addr_r, cur_addr_nxt;
  logic [DATA_W-2:0]   rx_r, rx_nxt;
  logic [DATA_W-1:0]   tx_r, tx_nxt;
  logic                word_done_r, word_done_nxt;
  logic                fetch_wait_r, fetch_wait_nxt;
  logic                sdo_nxt, sdo_oe_nxt, mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt, rx_shift_s;
  logic                frame_done_nxt, frame_err_nxt, abort_s, last_bit_s;

  assign rx_shift_s = {rx_r, sdi_s};
  assign last_bit_s = (bit_cnt_r == CNT_W'(DATA_W - 1));
  assign abort_s    = (state_r == ST_ADDR) || (state_r == ST_CMD) ||
                      (bit_cnt_r != {CNT_W{1'b0}}) || !word_done_r;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= {CNT_W{1'b0}};
      cur_addr_r   <= {ADDR_W{1'b0}};
      rx_r         <= {(DATA_W-1){1'b0}};
      tx_r         <= {DATA_W{1'b0}};
      word_done_r  <= 1'b0;
      fetch_wait_r <= 1'b0;
      sdo          <= 1'b1;
      sdo_oe       <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      bit_cnt_r    <= bit_cnt_nxt;
      cur_addr_r   <= cur_addr_nxt;
      rx_r         <= rx_nxt;
      tx_r         <= tx_nxt;
      word_done_r  <= word_done_nxt;
      fetch_wait_r <= fetch_wait_nxt;
      sdo          <= sdo_nxt;
      sdo_oe       <= sdo_oe_nxt;
      mem_req      <= mem_req_nxt;
      mem_we       <= mem_we_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      frame_done   <= frame_done_nxt;
      frame_err    <= frame_err_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt      = state_r;
    bit_cnt_nxt    = bit_cnt_r;
    cur_addr_nxt   = cur_addr_r;
    rx_nxt         = rx_r;
    tx_nxt         = tx_r;
    word_done_nxt  = word_done_r;
    fetch_wait_nxt = 1'b0;
    mem_req_nxt    = 1'b0;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    frame_done_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    // csz rising ends any frame and takes priority over a coincident sample edge
    if ((state_r != ST_IDLE) && csz_rise_s) begin
      state_nxt      = ST_IDLE;
      bit_cnt_nxt    = {CNT_W{1'b0}};
      frame_err_nxt  = abort_s;
      frame_done_nxt = !abort_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (csz_fall_s) begin
            state_nxt     = ST_ADDR;
            bit_cnt_nxt   = {CNT_W{1'b0}};
            word_done_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (sample_edge_s) begin
            cur_addr_nxt = {cur_addr_r[ADDR_W-2:0], sdi_s};
            if (bit_cnt_r == CNT_W'(ADDR_W - 1)) begin
              state_nxt   = ST_CMD;
              bit_cnt_nxt = {CNT_W{1'b0}};
            end else begin
              bit_cnt_nxt = bit_cnt_r + CNT_W'(1);
            end
          end else begin
            state_nxt = ST_ADDR;
          end
        end
        ST_CMD: begin
          if (sample_edge_s) begin
            bit_cnt_nxt = {CNT_W{1'b0}};
            if (sdi_s == RW_READ) begin
              state_nxt    = ST_RD_FETCH;
              mem_req_nxt  = 1'b1;
              mem_we_nxt   = 1'b0;
              mem_addr_nxt = cur_addr_r;
            end else begin
              state_nxt = ST_WR_SHIFT;
            end
          end else begin
            state_nxt = ST_CMD;
          end
        end
        ST_RD_FETCH: begin
          // mem_req is on the port during the first cycle; rdata arrives in the second
          if (fetch_wait_r) begin
            tx_nxt      = mem_rdata;
            state_nxt   = ST_RD_SHIFT;
            bit_cnt_nxt = {CNT_W{1'b0}};
          end else begin
            fetch_wait_nxt = 1'b1;
          end
        end
        ST_RD_SHIFT: begin
          if (sample_edge_s) begin
            if (last_bit_s) begin
              word_done_nxt = 1'b1;
              bit_cnt_nxt   = {CNT_W{1'b0}};
              if (BURST_EN) begin
                cur_addr_nxt = cur_addr_r + ADDR_W'(1);
                state_nxt    = ST_RD_FETCH;
                mem_req_nxt  = 1'b1;
                mem_we_nxt   = 1'b0;
                mem_addr_nxt = cur_addr_r + ADDR_W'(1);
              end else begin
                state_nxt = ST_DRAIN;
              end
            end else begin
              bit_cnt_nxt = bit_cnt_r + CNT_W'(1);
            end
          end else if (shift_edge_s && (bit_cnt_r != {CNT_W{1'b0}})) begin
            tx_nxt = {tx_r[DATA_W-2:0], 1'b1};
          end else begin
            state_nxt = ST_RD_SHIFT;
          end
        end
        ST_WR_SHIFT: begin
          if (sample_edge_s) begin
            rx_nxt = rx_shift_s[DATA_W-2:0];
            if (last_bit_s) begin
              mem_req_nxt   = 1'b1;
              mem_we_nxt    = 1'b1;
              mem_addr_nxt  = cur_addr_r;
              mem_wdata_nxt = rx_shift_s;
              word_done_nxt = 1'b1;
              bit_cnt_nxt   = {CNT_W{1'b0}};
              if (BURST_EN) begin
                cur_addr_nxt = cur_addr_r + ADDR_W'(1);
              end else begin
                state_nxt = ST_DRAIN;
              end
            end else begin
              bit_cnt_nxt = bit_cnt_r + CNT_W'(1);
            end
          end else begin
            state_nxt = ST_WR_SHIFT;
          end
        end
        ST_DRAIN: begin
          state_nxt = ST_DRAIN;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    sdo_oe_nxt = (state_nxt == ST_RD_SHIFT);
    sdo_nxt    = sdo_oe_nxt ? tx_nxt[DATA_W-1] : 1'b1;
  end

endmodule
